// File: rtl/panel_scan_ctrl_if.sv
// panel_scan_ctrl_if
//  Bundles every non-clock signal of the HUB75 row/PWM scan sequencer.
//  master : the scan controller (drives render request, panel address/latch/OE)
//  slave  : the surroundings (drives enable and line_render's done level)
//  Signals:
//   enable       run scanning while high
//   begin_out    one-cycle start pulse to line_render
//   done_in      line_render done level, high = row shifted
//   render_addr  row currently being shifted (5 bits)
//   render_pwm   PWM step of the row being shifted (7 bits)
//   panel_addr   row address on panel A..E (5 bits)
//   panel_lat    panel latch strobe, active high
//   panel_oe_n   panel output enable, active low
//   frame_start  one-cycle pulse at the start of each frame
interface panel_scan_ctrl_if;
    logic       enable;
    logic       begin_out;
    logic       done_in;
    logic [4:0] render_addr;
    logic [6:0] render_pwm;
    logic [4:0] panel_addr;
    logic       panel_lat;
    logic       panel_oe_n;
    logic       frame_start;

    modport master (
        input  enable,
        input  done_in,
        output begin_out,
        output render_addr,
        output render_pwm,
        output panel_addr,
        output panel_lat,
        output panel_oe_n,
        output frame_start
    );

    modport slave (
        output enable,
        output done_in,
        input  begin_out,
        input  render_addr,
        input  render_pwm,
        input  panel_addr,
        input  panel_lat,
        input  panel_oe_n,
        input  frame_start
    );
endinterface

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl
//  Row/PWM scan sequencer for the 96-px HUB75 panel path, sitting directly
//  upstream of line_render. Every row cycle it kicks line_render, keeps the
//  previously latched row lit for at least ON_CYC cycles while the next row
//  is shifted, blanks, latches, and moves the panel address on. Rows form the
//  inner loop and PWM steps the outer loop; one full sweep is one frame.
//  Ports:
//   clk_25MHz  system clock, everything on the rising edge
//   rst        asynchronous active-high reset
//   bus        panel_scan_ctrl_if.master (enable, done_in, begin_out,
//              render_addr, render_pwm, panel_addr, panel_lat, panel_oe_n,
//              frame_start)
module panel_scan_ctrl #(
    parameter int ROWS      = 32,
    parameter int PWM_STEPS = 128,
    parameter int ON_CYC    = 256,
    parameter int BLANK_CYC = 4,
    parameter int LATCH_CYC = 2
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    panel_scan_ctrl_if.master bus
);

    localparam int CW    = $clog2(ON_CYC + 1);
    localparam int PHMAX = (BLANK_CYC > LATCH_CYC) ? BLANK_CYC : LATCH_CYC;
    localparam int PW    = (PHMAX > 1) ? $clog2(PHMAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RENDER,
        ARM,
        WAIT_DONE,
        WAIT_ON,
        BLANK,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] on_cnt_q, on_cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [4:0]    render_addr_q, render_addr_d;
    logic [6:0]    render_pwm_q, render_pwm_d;
    logic [4:0]    panel_addr_q, panel_addr_d;
    logic          shown_q, shown_d;
    logic [CW-1:0] on_cnt_inc;

    // The on-period counter holds cycles elapsed since RENDER entry and
    // sticks at ON_CYC, so "reached" is a single equality test.
    assign on_cnt_inc = (on_cnt_q == CW'(ON_CYC)) ? on_cnt_q : on_cnt_q + 1'b1;

    // State and datapath registers; reset drops straight back to an idle,
    // dark panel with nothing marked as shown.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            on_cnt_q      <= '0;
            ph_q          <= '0;
            render_addr_q <= '0;
            render_pwm_q  <= '0;
            panel_addr_q  <= '0;
            shown_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            on_cnt_q      <= on_cnt_d;
            ph_q          <= ph_d;
            render_addr_q <= render_addr_d;
            render_pwm_q  <= render_pwm_d;
            panel_addr_q  <= panel_addr_d;
            shown_q       <= shown_d;
        end
    end

    // Next-state logic. Moving into BLANK happens once both the on-time has
    // elapsed and line_render reported done; the comparison uses the
    // incremented count so BLANK starts exactly max(ON_CYC, t_done+1) cycles
    // after RENDER. done_in is not looked at in ARM because line_render only
    // drops its previous done level one cycle after begin.
    always_comb begin
        state_d       = state_q;
        on_cnt_d      = on_cnt_q;
        ph_d          = ph_q;
        render_addr_d = render_addr_q;
        render_pwm_d  = render_pwm_q;
        panel_addr_d  = panel_addr_q;
        shown_d       = shown_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RENDER;
            end
            RENDER: begin
                on_cnt_d = CW'(1);
                state_d  = ARM;
            end
            ARM: begin
                on_cnt_d = on_cnt_inc;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                on_cnt_d = on_cnt_inc;
                if (bus.done_in) begin
                    state_d = (on_cnt_inc == CW'(ON_CYC)) ? BLANK : WAIT_ON;
                end
            end
            WAIT_ON: begin
                on_cnt_d = on_cnt_inc;
                if (on_cnt_inc == CW'(ON_CYC)) state_d = BLANK;
            end
            BLANK: begin
                if (ph_q == PW'(BLANK_CYC - 1)) begin
                    ph_d         = '0;
                    panel_addr_d = render_addr_q;
                    state_d      = LATCH;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LATCH: begin
                if (ph_q == PW'(LATCH_CYC - 1)) begin
                    ph_d = '0;
                    if (render_addr_q == 5'(ROWS - 1)) begin
                        render_addr_d = '0;
                        render_pwm_d  = (render_pwm_q == 7'(PWM_STEPS - 1)) ? '0 : render_pwm_q + 1'b1;
                    end else begin
                        render_addr_d = render_addr_q + 1'b1;
                    end
                    // A row just latched is only worth lighting if scanning continues.
                    shown_d = bus.enable;
                    state_d = bus.enable ? RENDER : IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the registered state so reset blanks the
    // panel and drops the latch in the same cycle it is asserted.
    always_comb begin
        bus.begin_out   = (state_q == RENDER);
        bus.frame_start = (state_q == RENDER) && (render_addr_q == '0) && (render_pwm_q == '0);
        bus.panel_lat   = (state_q == LATCH);
        bus.panel_oe_n  = 1'b1;
        if (shown_q && (state_q inside {RENDER, ARM, WAIT_DONE, WAIT_ON})) begin
            bus.panel_oe_n = 1'b0;
        end
        bus.render_addr = render_addr_q;
        bus.render_pwm  = render_pwm_q;
        bus.panel_addr  = panel_addr_q;
    end

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl
//  Bench for panel_scan_ctrl built with a small frame (4 rows x 4 PWM steps)
//  so whole frames wrap quickly, keeping the real on/blank/latch timing.
//  A planner turns each row's random line_render delay into the expected
//  row behaviour; a line_render stub replays those delays; a monitor pops
//  one expected row per begin_out and checks address, timing and OE rules.
module tb_panel_scan_ctrl;

    localparam int ROWS      = 4;
    localparam int PWM_STEPS = 4;
    localparam int ON_CYC    = 256;
    localparam int BLANK_CYC = 4;
    localparam int LATCH_CYC = 2;

    typedef struct {
        int addr;
        int pwm;
        int frameStart;
        int panelAddr;
        int oeLow;
        int tLat;
        int period;
    } ExpRow;

    logic clk_25MHz;
    logic rst;

    panel_scan_ctrl_if bus();

    panel_scan_ctrl #(
        .ROWS     (ROWS),
        .PWM_STEPS(PWM_STEPS),
        .ON_CYC   (ON_CYC),
        .BLANK_CYC(BLANK_CYC),
        .LATCH_CYC(LATCH_CYC)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .rst      (rst),
        .bus      (bus.master)
    );

    ExpRow expQ[$];
    int    delayQ[$];
    int    errors;
    int    checks;
    int    beginCount;
    int    rowsDone;

    int modelRow;
    int modelLatched;
    int modelShown;
    int modelPrevLen;

    // 25 MHz clock
    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: row n of a run shows row n%ROWS at PWM step
    // (n/ROWS)%PWM_STEPS; its lit time is max(ON_CYC, delay+1) unless it is
    // the first row since reset/idle, in which case nothing is lit.
    task automatic planRow(input int delay);
        ExpRow r;
        int    onLen;
        onLen        = (delay + 1 > ON_CYC) ? delay + 1 : ON_CYC;
        r.addr       = modelRow % ROWS;
        r.pwm        = (modelRow / ROWS) % PWM_STEPS;
        r.frameStart = (r.addr == 0 && r.pwm == 0) ? 1 : 0;
        r.panelAddr  = modelLatched;
        r.oeLow      = modelShown ? onLen : 0;
        r.tLat       = onLen + BLANK_CYC;
        r.period     = modelShown ? modelPrevLen : -1;
        expQ.push_back(r);
        delayQ.push_back(delay);
        modelPrevLen = onLen + BLANK_CYC + LATCH_CYC;
        modelLatched = r.addr;
        modelShown   = 1;
        modelRow++;
    endtask

    // Runs one burst of rows, then stops it either by dropping enable while
    // the last row is in its on-period or by pulsing reset during a latch.
    task automatic applyStimulus(input int nRows, input bit endByReset, input bit directed);
        int opening[7];
        int d;
        int target;
        int doneTarget;
        int limit;
        int begins0;
        int idleOeBad;
        opening = '{10, 10, 10, 300, 255, 256, 2};
        for (int i = 0; i < nRows; i++) begin
            if (directed && i < 7) d = opening[i];
            else if (!endByReset && i == nRows - 1) d = int'($urandom_range(2, 100));
            else d = int'($urandom_range(2, 320));
            planRow(d);
        end
        target     = beginCount + nRows;
        doneTarget = rowsDone + nRows;
        bus.enable = 1'b1;
        rst        = 1'b0;
        limit = 0;
        while (beginCount < target && limit < nRows * 400) begin
            @(negedge clk_25MHz);
            limit++;
        end
        checkOutput("rows_started", beginCount, target);
        if (!endByReset) begin
            repeat (128) @(negedge clk_25MHz);
            bus.enable = 1'b0;
            limit = 0;
            while (rowsDone < doneTarget && limit < 1000) begin
                @(negedge clk_25MHz);
                limit++;
            end
            checkOutput("rows_completed", rowsDone, doneTarget);
            begins0   = beginCount;
            idleOeBad = 0;
            repeat (20) begin
                @(negedge clk_25MHz);
                if (bus.panel_oe_n !== 1'b1) idleOeBad++;
            end
            checkOutput("idle_oe_low_cycles", idleOeBad, 0);
            checkOutput("idle_begin_count", beginCount, begins0);
            modelShown = 0;
        end else begin
            limit = 0;
            while (bus.panel_lat !== 1'b1 && limit < 1000) begin
                @(negedge clk_25MHz);
                limit++;
            end
            checkOutput("reached_latch", int'(bus.panel_lat), 1);
            rst = 1'b1;
            #1;
            checkOutput("rst_mid_latch_lat", int'(bus.panel_lat), 0);
            checkOutput("rst_mid_latch_oe_n", int'(bus.panel_oe_n), 1);
            checkOutput("rst_mid_latch_begin", int'(bus.begin_out), 0);
            checkOutput("rst_mid_latch_render_addr", int'(bus.render_addr), 0);
            checkOutput("rst_mid_latch_render_pwm", int'(bus.render_pwm), 0);
            checkOutput("rst_mid_latch_panel_addr", int'(bus.panel_addr), 0);
            bus.enable = 1'b0;
            repeat (3) @(negedge clk_25MHz);
            modelRow     = 0;
            modelLatched = 0;
            modelShown   = 0;
        end
    endtask

    // line_render stand-in: done stays at its old level through ARM, then
    // reads low until the planned delay after begin has passed.
    initial begin : doneStub
        int stubCyc;
        int stubDelay;
        stubCyc     = -1;
        stubDelay   = 2;
        bus.done_in = 1'b0;
        forever begin
            @(negedge clk_25MHz);
            if (rst) continue;
            if (bus.begin_out) begin
                stubCyc   = 0;
                stubDelay = (delayQ.size() > 0) ? delayQ.pop_front() : 2;
            end else if (stubCyc >= 0) begin
                stubCyc++;
            end
            if (stubCyc >= 2) bus.done_in = (stubCyc >= stubDelay);
        end
    end

    // Monitor: pops one expected row per begin_out and measures the row
    // (lit cycles, latch position/length, latched address, OE guard).
    initial begin : monitor
        ExpRow      cur;
        int         cyc;
        int         lastBegin;
        int         rowOeLow;
        int         rowTLat;
        int         rowLatLen;
        int         rowLatAddr;
        int         rowViol;
        bit         rowActive;
        bit         prevLat;
        logic [4:0] prevPanel;
        cyc = 0; lastBegin = 0; rowOeLow = 0; rowTLat = -1; rowLatLen = 0;
        rowLatAddr = 0; rowViol = 0; rowActive = 0; prevLat = 0; prevPanel = '0;
        forever begin
            @(negedge clk_25MHz);
            cyc++;
            if (rst) begin
                rowActive = 0;
                prevLat   = 0;
                prevPanel = bus.panel_addr;
                continue;
            end
            if (rowActive && prevLat && !bus.panel_lat) begin
                checkOutput("oe_low_cycles", rowOeLow, cur.oeLow);
                checkOutput("latch_offset", rowTLat, cur.tLat);
                checkOutput("latch_length", rowLatLen, LATCH_CYC);
                checkOutput("latched_addr", rowLatAddr, cur.addr);
                checkOutput("oe_guard_violations", rowViol, 0);
                rowsDone++;
                rowActive = 0;
            end
            if (bus.begin_out) begin
                beginCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_begin: got begin_out=1 for row %0d, expected no begin", bus.render_addr);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("render_addr", int'(bus.render_addr), cur.addr);
                    checkOutput("render_pwm", int'(bus.render_pwm), cur.pwm);
                    checkOutput("frame_start", int'(bus.frame_start), cur.frameStart);
                    checkOutput("panel_addr_at_begin", int'(bus.panel_addr), cur.panelAddr);
                    if (cur.period >= 0) checkOutput("row_period", cyc - lastBegin, cur.period);
                    rowActive = 1;
                end
                lastBegin = cyc;
                rowOeLow  = 0;
                rowTLat   = -1;
                rowLatLen = 0;
                rowViol   = 0;
            end
            if (rowActive) begin
                if (!bus.panel_oe_n) rowOeLow++;
                if (bus.panel_lat) begin
                    if (rowTLat < 0) begin
                        rowTLat    = cyc - lastBegin;
                        rowLatAddr = int'(bus.panel_addr);
                    end
                    rowLatLen++;
                end
                if (!bus.panel_oe_n && (bus.panel_lat || bus.panel_addr != prevPanel)) rowViol++;
            end
            prevLat   = bus.panel_lat;
            prevPanel = bus.panel_addr;
        end
    end

    // Main sequence: reset with enable high, a long directed+random run that
    // wraps a whole frame, a run cut by reset mid-latch, and a short rerun.
    initial begin : stimulus
        errors = 0; checks = 0; beginCount = 0; rowsDone = 0;
        modelRow = 0; modelLatched = 0; modelShown = 0; modelPrevLen = 0;
        rst        = 1'b1;
        bus.enable = 1'b1;
        repeat (5) @(negedge clk_25MHz);
        checkOutput("reset_begin_out", int'(bus.begin_out), 0);
        checkOutput("reset_panel_lat", int'(bus.panel_lat), 0);
        checkOutput("reset_panel_oe_n", int'(bus.panel_oe_n), 1);
        checkOutput("reset_frame_start", int'(bus.frame_start), 0);
        checkOutput("reset_panel_addr", int'(bus.panel_addr), 0);
        checkOutput("reset_render_addr", int'(bus.render_addr), 0);
        checkOutput("reset_render_pwm", int'(bus.render_pwm), 0);
        checkOutput("reset_begin_count", beginCount, 0);
        applyStimulus(20, 1'b0, 1'b1);
        applyStimulus(6, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("expected_rows_left", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
